// File: rtl/bf_program_loader.sv
// Streams ASCII Brainfuck source into the core's program memory as 3-bit
// instructions, validating bracket nesting and appending a terminator.
module bf_program_loader #(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int STACK_ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH       = 3
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_start,
  input  logic [7:0]                   i_byte,
  input  logic                         i_byte_valid,
  output logic                         o_byte_ready,
  output logic                         o_prgmem_in,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic [INSTR_WIDTH-1:0]       o_prgmem_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [2:0]                   o_error_code,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_length
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TERM  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [2:0] E_NONE      = 3'd0;
  localparam logic [2:0] E_UNMATCHED = 3'd1;
  localparam logic [2:0] E_UNCLOSED  = 3'd2;
  localparam logic [2:0] E_TOO_LONG  = 3'd3;
  localparam logic [2:0] E_TOO_DEEP  = 3'd4;

  localparam logic [INSTR_WIDTH-1:0] I_END   = '0;
  localparam logic [INSTR_WIDTH-1:0] I_INC   = INSTR_WIDTH'(2);
  localparam logic [INSTR_WIDTH-1:0] I_DEC   = INSTR_WIDTH'(3);
  localparam logic [INSTR_WIDTH-1:0] I_RIGHT = INSTR_WIDTH'(4);
  localparam logic [INSTR_WIDTH-1:0] I_LEFT  = INSTR_WIDTH'(5);
  localparam logic [INSTR_WIDTH-1:0] I_OPEN  = INSTR_WIDTH'(6);
  localparam logic [INSTR_WIDTH-1:0] I_CLOSE = INSTR_WIDTH'(7);

  localparam logic [STACK_ADDR_WIDTH:0]    DEPTH_MAX = (STACK_ADDR_WIDTH+1)'(1 << STACK_ADDR_WIDTH);
  localparam logic [PRGMEM_ADDR_WIDTH-1:0] ADDR_LAST = '1;

  logic [2:0]                   r_state;
  logic [PRGMEM_ADDR_WIDTH-1:0] r_addr;
  logic [STACK_ADDR_WIDTH:0]    r_depth;
  logic                         r_we;
  logic [PRGMEM_ADDR_WIDTH-1:0] r_wa;
  logic [INSTR_WIDTH-1:0]       r_wd;
  logic                         r_done;
  logic                         r_error;
  logic [2:0]                   r_code;

  logic                   w_is_cmd;
  logic                   w_is_end;
  logic [INSTR_WIDTH-1:0] w_instr;
  logic                   w_is_open;
  logic                   w_is_close;

  always_comb begin
    w_is_cmd = 1'b1;
    w_instr  = I_END;
    case (i_byte)
      8'h2B:   w_instr = I_INC;
      8'h2D:   w_instr = I_DEC;
      8'h3E:   w_instr = I_RIGHT;
      8'h3C:   w_instr = I_LEFT;
      8'h5B:   w_instr = I_OPEN;
      8'h5D:   w_instr = I_CLOSE;
      default: w_is_cmd = 1'b0;
    endcase
  end

  assign w_is_end   = (i_byte == 8'h00) || (i_byte == 8'h21);
  assign w_is_open  = w_is_cmd && (w_instr == I_OPEN);
  assign w_is_close = w_is_cmd && (w_instr == I_CLOSE);

  // r_addr doubles as the write count: it advances only on successful writes.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_depth <= '0;
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_code  <= E_NONE;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state <= S_LOAD;
            r_addr  <= '0;
            r_depth <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_code  <= E_NONE;
          end
        end
        S_LOAD: begin
          if (i_byte_valid) begin
            if (w_is_end) begin
              if (r_depth != '0) begin
                r_state <= S_ERROR;
                r_error <= 1'b1;
                r_code  <= E_UNCLOSED;
              end else begin
                // Terminator strobe is registered here so it is visible during TERM.
                r_state <= S_TERM;
                r_we    <= 1'b1;
                r_wa    <= r_addr;
                r_wd    <= I_END;
              end
            end else if (w_is_cmd) begin
              if (r_addr == ADDR_LAST) begin
                r_state <= S_ERROR;
                r_error <= 1'b1;
                r_code  <= E_TOO_LONG;
              end else if (w_is_open && (r_depth == DEPTH_MAX)) begin
                r_state <= S_ERROR;
                r_error <= 1'b1;
                r_code  <= E_TOO_DEEP;
              end else if (w_is_close && (r_depth == '0)) begin
                r_state <= S_ERROR;
                r_error <= 1'b1;
                r_code  <= E_UNMATCHED;
              end else begin
                r_we   <= 1'b1;
                r_wa   <= r_addr;
                r_wd   <= w_instr;
                r_addr <= r_addr + 1'b1;
                if (w_is_open) begin
                  r_depth <= r_depth + 1'b1;
                end else if (w_is_close) begin
                  r_depth <= r_depth - 1'b1;
                end
              end
            end
          end
        end
        S_TERM: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_byte_ready  = (r_state == S_LOAD);
  assign o_busy        = (r_state == S_LOAD) || (r_state == S_TERM);
  assign o_prgmem_in   = r_we;
  assign o_prgmem_addr = r_wa;
  assign o_prgmem_data = r_wd;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_error_code  = r_code;
  assign o_length      = r_addr;

endmodule
